// File: rtl/spi_sub_sync.sv
// SPI mode-0 subordinate fully resampled into the clk domain.
// Receives RX_W-bit command frames on mosi and returns a TX_W-bit response on miso.
module spi_sub_sync #(
    parameter int RX_W = 258,
    parameter int TX_W = 128
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cs_n,
    input  logic            sclk,
    input  logic            mosi,
    output logic            miso,
    input  logic [TX_W-1:0] tx_data,
    input  logic            tx_load,
    output logic [RX_W-1:0] rx_data,
    output logic            rx_valid,
    output logic            frame_err,
    output logic            busy
);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_END} state_t;

    localparam logic [8:0] RX_CNT = 9'(RX_W);

    state_t          state, state_nx;
    logic [2:0]      cs_p, sclk_p;
    logic [1:0]      mosi_p;
    logic [2:0]      flush;
    logic            armed;
    logic [TX_W-1:0] tx_buf, tx_sr;
    logic [RX_W-1:0] rx_sr;
    logic [8:0]      cnt;
    logic            cs_fall, cs_rise, sclk_rise, sclk_fall;

    // [1:0] is the synchronizer, [2] holds the previous synchronized value for edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_p   <= 3'b111;
            sclk_p <= 3'b000;
            mosi_p <= 2'b00;
        end else begin
            cs_p   <= {cs_p[1:0], cs_n};
            sclk_p <= {sclk_p[1:0], sclk};
            mosi_p <= {mosi_p[0], mosi};
        end
    end

    // A frame may only start after cs_n has genuinely been seen high once the
    // synchronizer has flushed its reset value; a frame cut by reset is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush <= '0;
            armed <= 1'b0;
        end else begin
            flush <= {flush[1:0], 1'b1};
            if (flush[2] && cs_p[2])
                armed <= 1'b1;
        end
    end

    assign cs_fall   = armed & cs_p[2] & ~cs_p[1];
    assign cs_rise   = ~cs_p[2] & cs_p[1];
    assign sclk_rise = sclk_p[1] & ~sclk_p[2];
    assign sclk_fall = ~sclk_p[1] & sclk_p[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (cs_fall) state_nx = S_ACTIVE;
            S_ACTIVE: if (cs_rise) state_nx = S_END;
            S_END:    state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_buf    <= '0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            cnt       <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            if (tx_load)
                tx_buf <= tx_data;
            case (state)
                S_IDLE: begin
                    if (cs_fall) begin
                        // a load coincident with frame start wins over the stale buffer
                        tx_sr <= tx_load ? tx_data : tx_buf;
                        rx_sr <= '0;
                        cnt   <= '0;
                    end
                end
                S_ACTIVE: begin
                    if (sclk_rise) begin
                        rx_sr <= {rx_sr[RX_W-2:0], mosi_p[1]};
                        if (cnt != '1)
                            cnt <= cnt + 9'd1;
                    end
                    if (sclk_fall)
                        tx_sr <= {tx_sr[TX_W-2:0], 1'b0};
                    // result is registered so the pulse lands in the END cycle
                    if (cs_rise) begin
                        if (cnt == RX_CNT) begin
                            rx_data  <= rx_sr;
                            rx_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign miso = (state == S_ACTIVE) ? tx_sr[TX_W-1] : 1'b0;
    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_spi_sub_sync.sv
// Directed bench for spi_sub_sync: SPI main model driving mode-0 frames.
module tb_spi_sub_sync;

    localparam int RX_W = 258;
    localparam int TX_W = 128;
    localparam int HP   = 6;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            cs_n = 1'b1;
    logic            sclk = 1'b0;
    logic            mosi = 1'b0;
    logic            miso;
    logic [TX_W-1:0] tx_data = '0;
    logic            tx_load = 1'b0;
    logic [RX_W-1:0] rx_data;
    logic            rx_valid;
    logic            frame_err;
    logic            busy;

    spi_sub_sync #(.RX_W(RX_W), .TX_W(TX_W)) dut (
        .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .sclk(sclk), .mosi(mosi), .miso(miso),
        .tx_data(tx_data), .tx_load(tx_load), .rx_data(rx_data), .rx_valid(rx_valid),
        .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int vcnt  = 0;
    int ecnt  = 0;
    logic [RX_W-1:0] vq[$];

    always @(negedge clk) begin
        if (rx_valid) begin
            vcnt++;
            vq.push_back(rx_data);
        end
        if (frame_err) ecnt++;
    end

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [TX_W-1:0] d);
        cyc(1);
        tx_data = d;
        tx_load = 1'b1;
        cyc(1);
        tx_load = 1'b0;
    endtask

    task automatic clr_mon();
        vcnt = 0;
        ecnt = 0;
        vq.delete();
    endtask

    // Send n bits of vec MSB first; capture the first TX_W miso bits and check the rest are 0.
    task automatic spi_frame(input logic [511:0] vec, input int n, input int rst_at,
                             input bit coinc, input logic [TX_W-1:0] cdata, input int gap,
                             output logic [TX_W-1:0] mrx, output bit tail_ok);
        mrx     = '0;
        tail_ok = 1'b1;
        cyc(1);
        cs_n = 1'b0;
        if (coinc) begin
            cyc(2);
            tx_data = cdata;
            tx_load = 1'b1;
            cyc(1);
            tx_load = 1'b0;
            cyc(HP - 3);
        end else begin
            cyc(HP);
        end
        for (int i = 0; i < n; i++) begin
            mosi = vec[n-1-i];
            cyc(HP);
            sclk = 1'b1;
            if (i < TX_W) mrx = {mrx[TX_W-2:0], miso};
            else if (miso !== 1'b0) tail_ok = 1'b0;
            if (i == rst_at) begin
                rst_n = 1'b0;
                #2;
                chk("rst_busy", busy, 0);
                chk("rst_miso", miso, 0);
                chk("rst_rx_data", rx_data, 0);
                chk("rst_valid", rx_valid, 0);
                chk("rst_ferr", frame_err, 0);
                cyc(2);
                rst_n = 1'b1;
            end
            cyc(HP);
            sclk = 1'b0;
        end
        cyc(HP);
        cs_n = 1'b1;
        mosi = 1'b0;
        cyc(gap);
    endtask

    localparam logic [RX_W-1:0] V1 = {2'b01, 256'h8E73B0F7DA0E6452C810F32B809079E562F8EAD2522C6B7B};
    localparam logic [RX_W-1:0] V2 = 258'h99999999999999999;
    localparam logic [RX_W-1:0] V3 = {2'b10, {32{8'hA5}}};
    localparam logic [RX_W-1:0] V4 = {2'b11, {32{8'h3C}}};

    logic [TX_W-1:0] mrx;
    bit              tail;

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        cyc(3);
        chk("reset_busy", busy, 0);
        chk("reset_miso", miso, 0);
        chk("reset_rx_data", rx_data, 0);
        chk("reset_valid", rx_valid, 0);
        chk("reset_ferr", frame_err, 0);
        rst_n = 1'b1;
        cyc(5);

        // valid frame
        load(128'h0);
        clr_mon();
        spi_frame(V1, RX_W, -1, 0, '0, 10, mrx, tail);
        chk("valid_rx_data", rx_data, V1);
        chk("valid_pulses", vcnt, 1);
        chk("valid_ferr", ecnt, 0);
        chk("valid_main_rx", mrx, 128'h0);
        chk("valid_busy_idle", busy, 0);

        // response path
        load(128'h555555555555555555);
        clr_mon();
        spi_frame(V2, RX_W, -1, 0, '0, 10, mrx, tail);
        chk("resp_main_rx", mrx, 128'h555555555555555555);
        chk("resp_rx_data", rx_data, V2);
        chk("resp_tail_zero", tail, 1);
        chk("resp_pulses", vcnt, 1);

        // short frame
        clr_mon();
        spi_frame(V1, 100, -1, 0, '0, 10, mrx, tail);
        chk("short_ferr", ecnt, 1);
        chk("short_valid", vcnt, 0);
        chk("short_rx_data", rx_data, V2);

        // over-length frame
        clr_mon();
        spi_frame({V1, 1'b1}, RX_W + 1, -1, 0, '0, 10, mrx, tail);
        chk("long_ferr", ecnt, 1);
        chk("long_valid", vcnt, 0);
        chk("long_rx_data", rx_data, V2);

        // reset mid-frame, then a clean frame
        clr_mon();
        spi_frame(V1, RX_W, 50, 0, '0, 10, mrx, tail);
        chk("rstmid_valid", vcnt, 0);
        chk("rstmid_ferr", ecnt, 0);
        chk("rstmid_rx_data", rx_data, 0);
        chk("rstmid_busy", busy, 0);
        clr_mon();
        spi_frame(V1, RX_W, -1, 0, '0, 10, mrx, tail);
        chk("rstmid_next_rx", rx_data, V1);
        chk("rstmid_next_pulses", vcnt, 1);

        // coincident load with cs_n fall detection
        load(128'h1234);
        clr_mon();
        spi_frame(V2, RX_W, -1, 1, 128'hfa4d, 10, mrx, tail);
        chk("coinc_main_rx", mrx, 128'hfa4d);
        chk("coinc_rx_data", rx_data, V2);
        spi_frame(V1, RX_W, -1, 0, '0, 10, mrx, tail);
        chk("reuse_main_rx", mrx, 128'hfa4d);

        // back-to-back with 4 clk of cs_n high
        clr_mon();
        spi_frame(V3, RX_W, -1, 0, '0, 4, mrx, tail);
        spi_frame(V4, RX_W, -1, 0, '0, 10, mrx, tail);
        chk("b2b_pulses", vcnt, 2);
        chk("b2b_ferr", ecnt, 0);
        if (vq.size() == 2) begin
            chk("b2b_first", vq[0], V3);
            chk("b2b_second", vq[1], V4);
        end else begin
            chk("b2b_queue_size", vq.size(), 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
